// File: rtl/r5p_bus_pkg.sv
// R5P system bus shared types and round-robin helper.
// Provides bus_req_t at default widths and rr_grant() for up to 8 ports.
package r5p_bus_pkg;

  localparam int BUS_AW = 15;
  localparam int BUS_DW = 32;
  localparam int BUS_BW = BUS_DW / 8;
  localparam int RR_MAXN = 8;

  typedef struct packed {
    logic              wen;
    logic [BUS_AW-1:0] adr;
    logic [BUS_BW-1:0] ben;
    logic [BUS_DW-1:0] wdt;
  } bus_req_t;

  // One-hot grant of the first requester found scanning
  // ptr, ptr+1, ... modulo n.
  function automatic logic [RR_MAXN-1:0] rr_grant(
    input logic [RR_MAXN-1:0] req,
    input logic [2:0]         ptr,
    input int unsigned        n
  );
    logic [RR_MAXN-1:0] g;
    logic               found;
    int unsigned        j;
    g     = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < RR_MAXN; k++) begin
      j = (32'(ptr) + k) % n;
      if (k < n && !found && req[j[2:0]]) begin
        g[j[2:0]] = 1'b1;
        found     = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/r5p_bus_arb_if.sv
// R5P vld/rdy bus bundle, N ports wide, flattened per-port fields.
// master drives vld/wen/adr/ben/wdt; slave returns rdy/rdt.
interface r5p_bus_arb_if #(
  parameter int N  = 1,
  parameter int AW = 15,
  parameter int DW = 32
);
  localparam int BW = DW / 8;

  logic [N-1:0]    vld;
  logic [N-1:0]    wen;
  logic [N*AW-1:0] adr;
  logic [N*BW-1:0] ben;
  logic [N*DW-1:0] wdt;
  logic [N*DW-1:0] rdt;
  logic [N-1:0]    rdy;

  modport master (
    output vld, wen, adr, ben, wdt,
    input  rdt, rdy
  );

  modport slave (
    input  vld, wen, adr, ben, wdt,
    output rdt, rdy
  );

endinterface

// File: rtl/r5p_bus_arb_rr.sv
// Round-robin grant with stall lock for r5p_bus_arb.
// Ports: req/rdy in, one-hot gnt and its index out.
module r5p_bus_arb_rr
  import r5p_bus_pkg::*;
#(
  parameter int BN = 2,
  parameter int IW = $clog2(BN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [BN-1:0] req,
  input  logic          rdy,
  output logic [BN-1:0] gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      own_q, own_d;
  logic               lock_q, lock_d;
  logic [RR_MAXN-1:0] rr_all;
  logic               hs;

  assign rr_all = rr_grant(RR_MAXN'(req), 3'(ptr_q), BN);
  assign hs     = (|req) & rdy;

  always_comb begin
    gnt    = lock_q ? (BN'(1) << own_q) : rr_all[BN-1:0];
    idx    = '0;
    for (int i = 0; i < BN; i++) begin
      if (gnt[i]) idx = IW'(i);
    end
    ptr_d  = ptr_q;
    own_d  = own_q;
    lock_d = lock_q;
    if (hs) begin
      lock_d = 1'b0;
      ptr_d  = (idx == IW'(BN - 1)) ? '0 : idx + 1'b1;
    end else if (|req) begin
      // Stalled request keeps the bus until it completes.
      lock_d = 1'b1;
      own_d  = idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      own_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      own_q  <= own_d;
      lock_q <= lock_d;
    end
  end

  a_gnt_oh: assert property (
    @(posedge clk) disable iff (!rst_n)
    $onehot0(gnt));

  a_lock: assert property (
    @(posedge clk) disable iff (!rst_n)
    lock_q && !hs |=> lock_q && own_q == $past(own_q));

endmodule

// File: rtl/r5p_bus_arb.sv
// BN-initiator to 1-responder R5P bus arbiter.
// Ports: clk, rst_n, s (initiators, slave side), m (responder, master side).
module r5p_bus_arb
  import r5p_bus_pkg::*;
#(
  parameter int BN  = 2,
  parameter int AW  = BUS_AW,
  parameter int DW  = BUS_DW,
  parameter int DLY = 1
) (
  input logic           clk,
  input logic           rst_n,
  r5p_bus_arb_if.slave  s,
  r5p_bus_arb_if.master m
);

  localparam int BW = DW / 8;
  localparam int IW = $clog2(BN);

  typedef struct packed {
    logic          wen;
    logic [AW-1:0] adr;
    logic [BW-1:0] ben;
    logic [DW-1:0] wdt;
  } req_t;

  logic [BN-1:0]    gnt;
  logic [IW-1:0]    gnt_idx;
  logic             mvld;
  logic             hs;
  req_t             req;
  logic             rd_push;
  logic             ret_vld;
  logic [IW-1:0]    ret_idx;
  logic [BN*DW-1:0] rdt;

  assign mvld = |s.vld;
  assign hs   = mvld & m.rdy;

  r5p_bus_arb_rr #(
    .BN (BN),
    .IW (IW)
  ) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (s.vld),
    .rdy   (m.rdy),
    .gnt   (gnt),
    .idx   (gnt_idx)
  );

  always_comb begin
    req = '0;
    for (int i = 0; i < BN; i++) begin
      if (gnt[i]) begin
        req.wen = s.wen[i];
        req.adr = s.adr[i*AW +: AW];
        req.ben = s.ben[i*BW +: BW];
        req.wdt = s.wdt[i*DW +: DW];
      end
    end
  end

  assign m.vld = mvld;
  assign m.wen = req.wen;
  assign m.adr = req.adr;
  assign m.ben = req.ben;
  assign m.wdt = req.wdt;
  assign s.rdy = {BN{m.rdy}} & gnt;

  assign rd_push = hs & ~req.wen;

  if (DLY == 0) begin : g_ret0
    assign ret_vld = rd_push;
    assign ret_idx = gnt_idx;
  end else begin : g_retp
    logic [DLY-1:0] vld_q, vld_d;
    logic [IW-1:0]  idx_q [DLY];
    logic [IW-1:0]  idx_d [DLY];

    always_comb begin
      vld_d    = DLY'({vld_q, rd_push});
      idx_d[0] = gnt_idx;
      for (int k = 1; k < DLY; k++) begin
        idx_d[k] = idx_q[k-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        for (int k = 0; k < DLY; k++) begin
          idx_q[k] <= '0;
        end
      end else begin
        vld_q <= vld_d;
        idx_q <= idx_d;
      end
    end

    assign ret_vld = vld_q[DLY-1];
    assign ret_idx = idx_q[DLY-1];
  end

  always_comb begin
    rdt = '0;
    for (int i = 0; i < BN; i++) begin
      if (ret_vld && ret_idx == IW'(i)) begin
        rdt[i*DW +: DW] = m.rdt;
      end
    end
  end

  assign s.rdt = rdt;

  a_rdy_req: assert property (
    @(posedge clk) disable iff (!rst_n)
    (s.rdy & ~s.vld) == '0);

endmodule

// File: tb/tb_r5p_bus_arb.sv
// Bench for r5p_bus_arb: BN=2/DLY=1 and BN=4/DLY=2 instances.
// Directed scenarios plus random traffic against a queue-based model.
module tb_r5p_bus_arb;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic [3:0]  vld;
  logic [3:0]  wen;
  logic [14:0] adr [4];
  logic [3:0]  ben [4];
  logic [31:0] wdt [4];
  logic        m_rdy;
  logic [31:0] m_rdt;
  logic        keep;

  r5p_bus_arb_if #(.N(2), .AW(15), .DW(32)) sa ();
  r5p_bus_arb_if #(.N(1), .AW(15), .DW(32)) ma ();
  r5p_bus_arb_if #(.N(4), .AW(15), .DW(32)) sb ();
  r5p_bus_arb_if #(.N(1), .AW(15), .DW(32)) mb ();

  r5p_bus_arb #(.BN(2), .AW(15), .DW(32), .DLY(1)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (sa),
    .m     (ma)
  );

  r5p_bus_arb #(.BN(4), .AW(15), .DW(32), .DLY(2)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (sb),
    .m     (mb)
  );

  assign sa.vld = sel ? 2'b00 : vld[1:0];
  assign sa.wen = wen[1:0];
  assign sa.adr = {adr[1], adr[0]};
  assign sa.ben = {ben[1], ben[0]};
  assign sa.wdt = {wdt[1], wdt[0]};
  assign ma.rdy = ~sel & m_rdy;
  assign ma.rdt = m_rdt;

  assign sb.vld = sel ? vld : 4'b0000;
  assign sb.wen = wen;
  assign sb.adr = {adr[3], adr[2], adr[1], adr[0]};
  assign sb.ben = {ben[3], ben[2], ben[1], ben[0]};
  assign sb.wdt = {wdt[3], wdt[2], wdt[1], wdt[0]};
  assign mb.rdy = sel & m_rdy;
  assign mb.rdt = m_rdt;

  logic        o_mvld;
  logic        o_mwen;
  logic [14:0] o_madr;
  logic [3:0]  o_mben;
  logic [31:0] o_mwdt;
  logic [3:0]  o_srdy;
  logic [31:0] o_srdt [4];

  always_comb begin
    o_mvld = 1'b0;
    o_mwen = 1'b0;
    o_madr = '0;
    o_mben = '0;
    o_mwdt = '0;
    o_srdy = '0;
    for (int i = 0; i < 4; i++) o_srdt[i] = '0;
    if (!sel) begin
      o_mvld    = ma.vld[0];
      o_mwen    = ma.wen[0];
      o_madr    = ma.adr;
      o_mben    = ma.ben;
      o_mwdt    = ma.wdt;
      o_srdy    = {2'b00, sa.rdy};
      o_srdt[0] = sa.rdt[31:0];
      o_srdt[1] = sa.rdt[63:32];
    end else begin
      o_mvld = mb.vld[0];
      o_mwen = mb.wen[0];
      o_madr = mb.adr;
      o_mben = mb.ben;
      o_mwdt = mb.wdt;
      o_srdy = sb.rdy;
      for (int i = 0; i < 4; i++) begin
        o_srdt[i] = sb.rdt[i*32 +: 32];
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: fairness pointer, lock owner, pending returns.
  typedef struct {
    int due;
    int idx;
  } ret_t;

  ret_t        rq [$];
  int          mp;
  int          mo;
  bit          ml;
  int          cyc;
  int          obs_g;
  logic [14:0] cap_madr;
  logic        cap_mwen;
  logic [3:0]  cap_mben;
  logic [31:0] cap_mwdt;
  logic [31:0] cap_rdt [4];

  function automatic int n_ports();
    return sel ? 4 : 2;
  endfunction

  function automatic int exp_grant();
    int bn;
    int j;
    bn = n_ports();
    if (ml) return mo;
    for (int k = 0; k < bn; k++) begin
      j = (mp + k) % bn;
      if (vld[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    mp = 0;
    mo = 0;
    ml = 1'b0;
    rq.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vld   = '0;
    m_rdy = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // Entered at a falling edge with inputs set; returns at the next one.
  task automatic step(input logic [31:0] rdt);
    int          g;
    int          bn;
    int          dly;
    bit          hs;
    logic [31:0] er;
    bn    = n_ports();
    dly   = sel ? 2 : 1;
    m_rdt = rdt;
    #4;
    g = exp_grant();
    chk("m_vld", 32'(o_mvld), 32'(|(vld & 4'((1 << bn) - 1))));
    chk("m_adr", 32'(o_madr), g >= 0 ? 32'(adr[g]) : 32'd0);
    chk("m_wen", 32'(o_mwen), g >= 0 ? 32'(wen[g]) : 32'd0);
    chk("m_ben", 32'(o_mben), g >= 0 ? 32'(ben[g]) : 32'd0);
    chk("m_wdt", o_mwdt, g >= 0 ? wdt[g] : 32'd0);
    chk("s_rdy", 32'(o_srdy),
        (g >= 0 && m_rdy) ? 32'(1 << g) : 32'd0);
    for (int i = 0; i < bn; i++) begin
      er = 32'd0;
      if (rq.size() > 0 && rq[0].due == cyc && rq[0].idx == i)
        er = m_rdt;
      chk($sformatf("s_rdt%0d", i), o_srdt[i], er);
    end
    obs_g = -1;
    for (int i = 0; i < 4; i++) if (o_srdy[i]) obs_g = i;
    cap_madr = o_madr;
    cap_mwen = o_mwen;
    cap_mben = o_mben;
    cap_mwdt = o_mwdt;
    for (int i = 0; i < 4; i++) cap_rdt[i] = o_srdt[i];
    @(posedge clk);
    if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
    hs = 1'b0;
    if (g >= 0 && m_rdy) begin
      hs = 1'b1;
      mp = (g + 1) % bn;
      ml = 1'b0;
      if (!wen[g]) rq.push_back('{cyc + dly, g});
    end else if (g >= 0) begin
      ml = 1'b1;
      mo = g;
    end
    cyc++;
    @(negedge clk);
    if (hs && !keep) vld[g] = 1'b0;
  endtask

  task automatic rand_run(input int n);
    int bn;
    bn = n_ports();
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < bn; i++) begin
        if (!vld[i] && $urandom_range(0, 2) == 0) begin
          vld[i] = 1'b1;
          wen[i] = 1'($urandom_range(0, 1));
          adr[i] = 15'($urandom);
          ben[i] = 4'($urandom);
          wdt[i] = $urandom;
        end
      end
      m_rdy = ($urandom_range(0, 3) != 0);
      step($urandom);
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    cyc   = 0;
    sel   = 1'b0;
    keep  = 1'b0;
    rst_n = 1'b0;
    vld   = '0;
    wen   = '0;
    m_rdy = 1'b0;
    m_rdt = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      adr[i] = '0;
      ben[i] = '0;
      wdt[i] = '0;
    end
    model_reset();
    @(negedge clk);
    chk("rst_mvld", 32'(o_mvld), 32'd0);
    chk("rst_srdy", 32'(o_srdy), 32'd0);
    chk("rst_rdt0", o_srdt[0], 32'd0);
    chk("rst_rdt1", o_srdt[1], 32'd0);
    #2;
    rst_n = 1'b1;
    @(negedge clk);

    // Two ports always requesting alternate.
    keep   = 1'b1;
    vld    = 4'b0011;
    wen    = '0;
    adr[0] = 15'h0100;
    adr[1] = 15'h0200;
    m_rdy  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step($urandom);
      chk("fair2_g", 32'(obs_g), 32'(k % 2));
      chk("fair2_adr", 32'(cap_madr),
          (k % 2) ? 32'h0200 : 32'h0100);
    end
    keep = 1'b0;
    vld  = '0;
    step($urandom);
    step($urandom);

    // Stall holds the grant even when the pointer favours port1.
    do_reset();
    vld[0] = 1'b1;
    adr[0] = 15'h0004;
    m_rdy  = 1'b1;
    step($urandom);
    vld[0] = 1'b1;
    adr[0] = 15'h0010;
    m_rdy  = 1'b0;
    step($urandom);
    chk("stall_adr0", 32'(cap_madr), 32'h0010);
    vld[1] = 1'b1;
    adr[1] = 15'h0020;
    for (int k = 0; k < 2; k++) begin
      step($urandom);
      chk("stall_adr", 32'(cap_madr), 32'h0010);
    end
    m_rdy = 1'b1;
    step($urandom);
    chk("stall_hs", 32'(obs_g), 32'd0);
    step($urandom);
    chk("stall_next", 32'(obs_g), 32'd1);
    chk("stall_nadr", 32'(cap_madr), 32'h0020);

    // Back-to-back reads return to their own owners.
    do_reset();
    vld    = 4'b0011;
    wen    = '0;
    adr[0] = 15'h0004;
    adr[1] = 15'h0008;
    m_rdy  = 1'b1;
    step($urandom);
    chk("b2b_g0", 32'(obs_g), 32'd0);
    step(32'hAAAA_0000);
    chk("b2b_g1", 32'(obs_g), 32'd1);
    chk("b2b_r0", cap_rdt[0], 32'hAAAA_0000);
    chk("b2b_r0o", cap_rdt[1], 32'd0);
    step(32'h5555_0000);
    chk("b2b_r1", cap_rdt[1], 32'h5555_0000);
    chk("b2b_r1o", cap_rdt[0], 32'd0);

    // Write is forwarded and gets no read response.
    vld[1] = 1'b1;
    wen[1] = 1'b1;
    adr[1] = 15'h0030;
    ben[1] = 4'b0011;
    wdt[1] = 32'h1234_5678;
    step($urandom);
    chk("wr_wen", 32'(cap_mwen), 32'd1);
    chk("wr_ben", 32'(cap_mben), 32'h3);
    chk("wr_wdt", cap_mwdt, 32'h1234_5678);
    step(32'hFFFF_FFFF);
    chk("wr_nordt", cap_rdt[1], 32'd0);
    wen = '0;

    rand_run(200);

    // Four ports, all requesting.
    sel = 1'b1;
    do_reset();
    keep = 1'b1;
    vld  = 4'b1111;
    wen  = '0;
    for (int i = 0; i < 4; i++) adr[i] = 15'(i * 'h40);
    m_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step($urandom);
      chk("fair4_g", 32'(obs_g), 32'(k % 4));
    end
    keep = 1'b0;
    vld  = '0;
    for (int k = 0; k < 3; k++) step($urandom);

    // Reset with a read in flight and a lock pending.
    do_reset();
    vld[2] = 1'b1;
    adr[2] = 15'h0077;
    m_rdy  = 1'b1;
    step($urandom);
    chk("inf_g", 32'(obs_g), 32'd2);
    vld[3] = 1'b1;
    m_rdy  = 1'b0;
    step($urandom);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(32'hCAFE_F00D);
      for (int i = 0; i < 4; i++) begin
        chk("rst_inf_rdt", cap_rdt[i], 32'd0);
      end
    end
    vld   = 4'b1111;
    m_rdy = 1'b1;
    step($urandom);
    chk("rst_ptr", 32'(obs_g), 32'd0);
    vld = '0;
    step($urandom);
    step($urandom);

    rand_run(300);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
